// File: rtl/ahb_sif.sv
// ahb_sif: AHB-Lite slave memory model for simulation.
// It holds a byte-addressed array that a testbench can preload, returns
// 64-bit read data and performs byte-lane writes. The mailbox address raises
// mailbox_write for one cycle so a testbench can print characters or detect
// the end of a test.
//
// Build option: define AHB_SIF_WAIT_STATE_EN to insert one wait state into
// every data phase. Without it the slave has zero wait states.
//
// Handshake: an address phase is accepted when HSEL & HREADY & HTRANS[1] and,
// with wait states enabled, also HREADYOUT. Its data phase ends on the first
// rising edge where HREADYOUT is 1. Read data is captured when the address
// phase is accepted. A write commits on the edge that ends its data phase.
module ahb_sif #(
    parameter int          MEM_AW       = 20,
    parameter logic [31:0] MAILBOX_ADDR = 32'hD058_0000
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBURST,
    input  logic [3:0]  HPROT,
    input  logic        HREADY,
    input  logic [63:0] HWDATA,
    output logic        HREADYOUT,
    output logic        HRESP,
    output logic [63:0] HRDATA
);

    // Backing store. It has no reset, so preloaded contents survive reset.
    logic [7:0]  mem [0:(2**MEM_AW)-1];

    logic        mailbox_write;
    logic [63:0] WriteData;

    // Data-phase control captured from the accepted address phase.
    logic        dp_valid;
    logic [31:0] Last_HADDR;
    logic [2:0]  Last_HSIZE;
    logic        Last_HWRITE;

    logic        hreadyout_q;
    logic        addr_accept;
    logic        wr_commit;
    logic [3:0]  wr_lo;
    logic [3:0]  wr_hi;
    logic [7:0]  wr_lane_en;
    logic        same_dword;
    logic [63:0] rd_merged;

    // HBURST and HPROT have no effect on a flat memory.
    logic        unused_ok;
    assign unused_ok = ^{HBURST, HPROT};

`ifdef AHB_SIF_WAIT_STATE_EN
    assign addr_accept = HSEL & HREADY & HTRANS[1] & hreadyout_q;

    // HREADYOUT is low in the first data-phase cycle and high in the second.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hreadyout_q <= 1'b1;
        end else begin
            hreadyout_q <= ~addr_accept;
        end
    end
`else
    assign addr_accept = HSEL & HREADY & HTRANS[1];
    assign hreadyout_q = 1'b1;
`endif

    // Capture the data-phase control on accept. The data phase ends when HREADYOUT is high.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dp_valid    <= 1'b0;
            Last_HADDR  <= 32'h0;
            Last_HSIZE  <= 3'h0;
            Last_HWRITE <= 1'b0;
        end else begin
            if (hreadyout_q) begin
                dp_valid <= addr_accept;
            end
            if (addr_accept) begin
                Last_HADDR  <= HADDR;
                Last_HSIZE  <= HSIZE;
                Last_HWRITE <= HWRITE;
            end
        end
    end

    assign wr_commit     = dp_valid & Last_HWRITE & hreadyout_q;
    assign mailbox_write = wr_commit & (Last_HADDR == MAILBOX_ADDR);
    assign WriteData     = HWDATA;

    // Byte lanes written by the committing write. Lanes past byte 7 are dropped.
    always_comb begin
        wr_lo = {1'b0, Last_HADDR[2:0]};
        wr_hi = wr_lo;
        case (Last_HSIZE)
            3'd0:    wr_hi = wr_lo + 4'd1;
            3'd1:    wr_hi = wr_lo + 4'd2;
            3'd2:    wr_hi = wr_lo + 4'd4;
            default: wr_hi = wr_lo + 4'd8;
        endcase
        wr_lane_en = 8'h00;
        for (int i = 0; i < 8; i++) begin
            wr_lane_en[i] = wr_commit && (4'(i) >= wr_lo) && (4'(i) < wr_hi);
        end
    end

    // Write the enabled lanes into the addressed dword.
    always_ff @(posedge HCLK) begin
        for (int i = 0; i < 8; i++) begin
            if (wr_lane_en[i]) begin
                mem[{Last_HADDR[MEM_AW-1:3], 3'(i)}] <= HWDATA[8*i +: 8];
            end
        end
    end

    // Build the read dword. Bytes that a write to the same dword commits on this edge are forwarded.
    always_comb begin
        same_dword = (HADDR[MEM_AW-1:3] == Last_HADDR[MEM_AW-1:3]);
        rd_merged  = 64'h0;
        for (int i = 0; i < 8; i++) begin
            if (same_dword && wr_lane_en[i]) begin
                rd_merged[8*i +: 8] = HWDATA[8*i +: 8];
            end else begin
                rd_merged[8*i +: 8] = mem[{HADDR[MEM_AW-1:3], 3'(i)}];
            end
        end
    end

    // Register the read data when a read is accepted. It holds until the next accepted read.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HRDATA <= 64'h0;
        end else if (addr_accept && !HWRITE) begin
            HRDATA <= rd_merged;
        end
    end

    assign HREADYOUT = hreadyout_q;
    assign HRESP     = 1'b0;

endmodule

// File: tb/tb_ahb_sif.sv
// tb_ahb_sif: randomized bench for ahb_sif in the default zero-wait build.
// A flat byte-array model of memory predicts every read, and the pending
// data phase predicts the mailbox pulse.
module tb_ahb_sif;

    localparam int          MEM_AW = 20;
    localparam logic [31:0] MBOX   = 32'hD058_0000;
    localparam logic [1:0]  IDLE   = 2'd0;
    localparam logic [1:0]  BUSY   = 2'd1;
    localparam logic [1:0]  NONSEQ = 2'd2;
    localparam logic [1:0]  SEQ    = 2'd3;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic [63:0] HWDATA;
    logic        HREADYOUT;
    logic        HRESP;
    logic [63:0] HRDATA;

    ahb_sif #(.MEM_AW(MEM_AW), .MAILBOX_ADDR(MBOX)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HBURST    (HBURST),
        .HPROT     (HPROT),
        .HREADY    (HREADY),
        .HWDATA    (HWDATA),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA)
    );

    // Clock
    always #5 HCLK = ~HCLK;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference memory and the pending data phase
    logic [7:0]  ref_mem [0:(1<<MEM_AW)-1];
    logic        pend_vld;
    logic        pend_wr;
    logic [31:0] pend_addr;
    logic [2:0]  pend_size;
    logic [63:0] pend_wdata;

    function automatic logic [63:0] ref_read(input logic [31:0] a);
        logic [63:0] d;
        int base;
        base = int'(a[MEM_AW-1:3]) * 8;
        for (int b = 0; b < 8; b++) d[8*b +: 8] = ref_mem[base + b];
        return d;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [2:0] size, input logic [63:0] wd);
        int base;
        int lo;
        int n;
        base = int'(a[MEM_AW-1:3]) * 8;
        lo   = int'(a[2:0]);
        n    = 1 << size;
        for (int b = lo; b < lo + n && b < 8; b++) ref_mem[base + b] = wd[8*b +: 8];
    endtask

    // One bus cycle. It starts and ends 1 time unit after a rising edge.
    // It drives an address phase and the write data of the previous phase.
    task automatic beat(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [31:0] addr, input logic [2:0] size,
                        input logic rdy, input logic [63:0] wd);
        logic acc;
        logic mbox_exp;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HADDR  = addr;
        HSIZE  = size;
        HREADY = rdy;
        HBURST = 3'($urandom);
        HPROT  = 4'($urandom);
        HWDATA = (pend_vld && pend_wr) ? pend_wdata : {$urandom, $urandom};
        #1;
        mbox_exp = pend_vld && pend_wr && (pend_addr == MBOX);
        check_eq("mailbox_write", 64'(dut.mailbox_write), 64'(mbox_exp));
        if (mbox_exp) check_eq("mailbox_data", 64'(dut.WriteData[7:0]), 64'(pend_wdata[7:0]));
        check_eq("hreadyout", 64'(HREADYOUT), 64'd1);
        check_eq("hresp", 64'(HRESP), 64'd0);
        @(posedge HCLK);
        if (pend_vld && pend_wr) ref_write(pend_addr, pend_size, pend_wdata);
        acc = sel && rdy && trans[1];
        #1;
        if (acc && !wr) check_eq("hrdata", HRDATA, ref_read(addr));
        pend_vld   = acc;
        pend_wr    = wr;
        pend_addr  = addr;
        pend_size  = size;
        pend_wdata = wd;
    endtask

    task automatic idle_beat();
        beat(1'b0, IDLE, 1'b0, 32'h0, 3'd0, 1'b1, 64'h0);
    endtask

    initial begin
        logic [7:0]  v;
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic        rdy;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [63:0] old_dw;

        HRESETn = 1'b0;
        HSEL = 1'b0; HADDR = 32'h0; HTRANS = IDLE; HWRITE = 1'b0; HSIZE = 3'd0;
        HBURST = 3'd0; HPROT = 4'd0; HREADY = 1'b1; HWDATA = 64'h0;
        pend_vld = 1'b0; pend_wr = 1'b0; pend_addr = 32'h0; pend_size = 3'd0; pend_wdata = 64'h0;

        // Preload the test window and the aliased mailbox dword
        for (int i = 0; i < 4096; i++) begin
            v = 8'($urandom);
            dut.mem[i] = v;
            ref_mem[i] = v;
        end
        for (int i = 0; i < 8; i++) begin
            v = 8'(8'h11 * (i + 1));
            dut.mem[i] = v;
            ref_mem[i] = v;
            v = 8'($urandom);
            dut.mem[32'h80000 + i] = v;
            ref_mem[32'h80000 + i] = v;
        end

        // Reset
        repeat (2) @(posedge HCLK);
        #1;
        check_eq("rst_hreadyout", 64'(HREADYOUT), 64'd1);
        check_eq("rst_hresp", 64'(HRESP), 64'd0);
        check_eq("rst_hrdata", HRDATA, 64'h0);
        check_eq("rst_mailbox", 64'(dut.mailbox_write), 64'd0);
        HRESETn = 1'b1;
        idle_beat();

        // Preload then read
        beat(1'b1, NONSEQ, 1'b0, 32'h8000_0000, 3'd3, 1'b1, 64'h0);
        check_eq("preload_read", HRDATA, 64'h8877665544332211);

        // Byte-lane write, then a read that hits the committing write
        beat(1'b1, NONSEQ, 1'b1, 32'h8000_0005, 3'd0, 1'b1, 64'h0000_AB00_0000_0000);
        beat(1'b1, NONSEQ, 1'b0, 32'h8000_0000, 3'd3, 1'b1, 64'h0);
        check_eq("byte_lane", HRDATA, 64'h8877AB5544332211);

        // Back-to-back write and read bypass
        beat(1'b1, NONSEQ, 1'b1, 32'h0000_0100, 3'd2, 1'b1, 64'h0000_0000_DEAD_BEEF);
        beat(1'b1, SEQ, 1'b0, 32'h0000_0100, 3'd3, 1'b1, 64'h0);
        check_eq("bypass", 64'(HRDATA[31:0]), 64'hDEAD_BEEF);

        // Two mailbox writes, each giving one pulse
        beat(1'b1, NONSEQ, 1'b1, MBOX, 3'd0, 1'b1, 64'h41);
        beat(1'b1, NONSEQ, 1'b1, MBOX, 3'd0, 1'b1, 64'hFF);
        idle_beat();
        idle_beat();

        // BUSY, IDLE and HREADY=0 writes have no effect
        beat(1'b1, BUSY, 1'b1, 32'h8000_0000, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b1, IDLE, 1'b1, 32'h8000_0000, 3'd3, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b1, NONSEQ, 1'b1, 32'h8000_0000, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        beat(1'b1, BUSY, 1'b1, MBOX, 3'd0, 1'b1, 64'h42);
        beat(1'b1, NONSEQ, 1'b1, MBOX, 3'd0, 1'b0, 64'h43);
        beat(1'b1, NONSEQ, 1'b0, 32'h8000_0000, 3'd3, 1'b1, 64'h0);
        check_eq("no_write", HRDATA, 64'h8877AB5544332211);

        // Reset during a write data phase drops the write
        old_dw = ref_read(32'h200);
        beat(1'b1, NONSEQ, 1'b1, 32'h0000_0200, 3'd3, 1'b1, ~old_dw);
        HRESETn = 1'b0;
        HSEL = 1'b0; HTRANS = IDLE;
        @(posedge HCLK);
        #1;
        check_eq("midrst_hrdata", HRDATA, 64'h0);
        check_eq("midrst_mailbox", 64'(dut.mailbox_write), 64'd0);
        HRESETn = 1'b1;
        pend_vld = 1'b0;
        beat(1'b1, NONSEQ, 1'b0, 32'h0000_0200, 3'd3, 1'b1, 64'h0);
        check_eq("midrst_lost", HRDATA, old_dw);

        // Randomized pipelined traffic
        for (int n = 0; n < 600; n++) begin
            sel   = ($urandom_range(0, 9) != 0);
            trans = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            size  = 3'($urandom_range(0, 3));
            rdy   = pend_vld ? 1'b1 : ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 19) == 0) begin
                addr = MBOX;
            end else if ($urandom_range(0, 1) == 0) begin
                addr = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 31));
            end else begin
                addr = ($urandom & 32'hFFF0_0000) | 32'($urandom_range(0, 4095));
            end
            beat(sel, trans, wr, addr, size, rdy, {$urandom, $urandom});
        end
        idle_beat();

        // Read back the low window after the random traffic
        for (int a = 0; a < 64; a += 8) begin
            beat(1'b1, NONSEQ, 1'b0, 32'(a), 3'd3, 1'b1, 64'h0);
        end
        idle_beat();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
